// File: rtl/seq_mult_eight_eight_pkg.sv
// ----------------------------------------------------------------------------
// seq_mult_eight_eight_pkg
// Shared constants for the multi-cycle 8x8 multiplier:
//   - FSM state encoding (IDLE / MUL / DONE)
//   - number of nibble steps and index of the last one
//   - per-step left shift applied to the 4x4 partial product
// ----------------------------------------------------------------------------
package seq_mult_eight_eight_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned NUM_STEPS = 4;
   localparam logic [1:0]  LAST_STEP = 2'(NUM_STEPS - 1);

   // Step order: lo*lo, hi*lo, lo*hi, hi*hi
   function automatic logic [3:0] step_shift(input logic [1:0] step);
      case (step)
         2'd0:    step_shift = 4'd0;
         2'd1:    step_shift = 4'd4;
         2'd2:    step_shift = 4'd4;
         default: step_shift = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/seq_mult_eight_eight_if.sv
// ----------------------------------------------------------------------------
// seq_mult_eight_eight_if
// Operand and result handshakes of the sequential 8x8 multiplier.
//   in_valid  : operand pair a/b valid          (upstream -> multiplier)
//   in_ready  : multiplier accepts a pair        (multiplier -> upstream)
//   a, b      : 8-bit unsigned operands          (upstream -> multiplier)
//   out_valid : product holds a finished result  (multiplier -> downstream)
//   out_ready : downstream takes the result      (downstream -> multiplier)
//   product   : 16-bit unsigned result           (multiplier -> downstream)
// master = environment side, slave = multiplier side.
// ----------------------------------------------------------------------------
interface seq_mult_eight_eight_if;
   import seq_mult_eight_eight_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product
   );

endinterface

// File: rtl/wallace_tree_four_four.sv
// ----------------------------------------------------------------------------
// wallace_tree_four_four
// Combinational unsigned 4x4 multiplier. Four shifted AND rows are reduced
// with two carry-save layers and one final carry-propagate add.
//   a_i : 4-bit multiplicand
//   b_i : 4-bit multiplier
//   p_o : 8-bit product
// ----------------------------------------------------------------------------
module wallace_tree_four_four (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] p_o
);

   logic [7:0] row0, row1, row2, row3;
   logic [7:0] s1, c1, c1_sh;
   logic [7:0] s2, c2, c2_sh;

   always_comb begin
      row0 = b_i[0] ? {4'd0, a_i}       : 8'd0;
      row1 = b_i[1] ? {3'd0, a_i, 1'b0} : 8'd0;
      row2 = b_i[2] ? {2'd0, a_i, 2'd0} : 8'd0;
      row3 = b_i[3] ? {1'd0, a_i, 3'd0} : 8'd0;

      // First 3:2 layer over rows 0..2
      s1    = row0 ^ row1 ^ row2;
      c1    = (row0 & row1) | (row0 & row2) | (row1 & row2);
      c1_sh = c1 << 1;

      // Second 3:2 layer folds in row 3
      s2    = s1 ^ c1_sh ^ row3;
      c2    = (s1 & c1_sh) | (s1 & row3) | (c1_sh & row3);
      c2_sh = c2 << 1;

      // The full product never exceeds 225, so no 8-bit intermediate overflows
      p_o   = s2 + c2_sh;
   end

endmodule

// File: rtl/seq_mult_eight_eight.sv
// ----------------------------------------------------------------------------
// seq_mult_eight_eight
// Multi-cycle unsigned 8x8 multiplier. One operand pair is accepted through
// a valid/ready handshake, four nibble products from a 4x4 Wallace core are
// shift-accumulated over four MUL cycles, and the 16-bit result is offered
// through a second valid/ready handshake.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : operand/result handshakes (slave side of seq_mult_eight_eight_if)
// ----------------------------------------------------------------------------
module seq_mult_eight_eight
   import seq_mult_eight_eight_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   seq_mult_eight_eight_if.slave bus
);

   state_t      state_q, state_d;
   logic [1:0]  step_q,  step_d;
   logic [7:0]  a_q,     a_d;
   logic [7:0]  b_q,     b_d;
   logic [15:0] acc_q,   acc_d;

   logic [3:0]  core_a, core_b;
   logic [7:0]  core_p;
   logic [15:0] pp_ext;

   // step[0] selects the high nibble of a, step[1] the high nibble of b
   assign core_a = step_q[0] ? a_q[7:4] : a_q[3:0];
   assign core_b = step_q[1] ? b_q[7:4] : b_q[3:0];
   assign pp_ext = {8'd0, core_p};

   wallace_tree_four_four u_core (
      .a_i (core_a),
      .b_i (core_b),
      .p_o (core_p)
   );

   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      a_d           = a_q;
      b_d           = b_q;
      acc_d         = acc_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               acc_d   = 16'd0;
               step_d  = 2'd0;
               state_d = ST_MUL;
            end
         end

         ST_MUL: begin
            acc_d  = acc_q + (pp_ext << step_shift(step_q));
            step_d = step_q + 2'd1;
            if (step_q == LAST_STEP) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            bus.out_valid = 1'b1;
            // Readiness follows the consumer so a new pair can enter on the
            // same edge the finished result leaves.
            bus.in_ready  = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  a_d     = bus.a;
                  b_d     = bus.b;
                  acc_d   = 16'd0;
                  step_d  = 2'd0;
                  state_d = ST_MUL;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= 2'd0;
         a_q     <= 8'd0;
         b_q     <= 8'd0;
         acc_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

   assign bus.product = acc_q;

endmodule

// File: tb/tb_seq_mult_eight_eight.sv
// ----------------------------------------------------------------------------
// tb_seq_mult_eight_eight
// Directed bench for seq_mult_eight_eight: reset, single op, corner values,
// backpressure, back-to-back, reset mid-operation, in_valid during MUL.
// ----------------------------------------------------------------------------
module tb_seq_mult_eight_eight;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   seq_mult_eight_eight_if bus ();

   seq_mult_eight_eight dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) until out_valid is high; lat = edges waited.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   // Accepts one pair with out_ready high, returns product and latency,
   // then lets the handoff edge pass.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] prod, output int lat);
      bus.a         = a;
      bus.b         = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
      wait_valid(lat);
      prod = bus.product;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.product !== 16'h0000) begin
         errors++; $display("FAIL reset_product: got %h expected 0000", bus.product);
      end
   endtask

   task automatic test_single();
      logic [15:0] p;
      int          lat;
      run_op(8'h12, 8'h34, p, lat);
      checks++;
      if (lat !== 4) begin
         errors++; $display("FAIL single_latency: got %0d expected 4", lat);
      end
      checks++;
      if (p !== 16'h03A8) begin
         errors++; $display("FAIL single_product: got %h expected 03a8", p);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL single_back_to_idle: got out_valid=%b in_ready=%b expected 0/1",
                            bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_corners();
      logic [7:0]  va [4] = '{8'hFF, 8'hA5, 8'h01, 8'hF0};
      logic [7:0]  vb [4] = '{8'hFF, 8'h00, 8'h80, 8'h0F};
      logic [15:0] ve [4] = '{16'hFE01, 16'h0000, 16'h0080, 16'h0E10};
      logic [15:0] p;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], p, lat);
         checks++;
         if (p !== ve[i] || lat !== 4) begin
            errors++;
            $display("FAIL corner_%0d: got %h (lat %0d) expected %h (lat 4)", i, p, lat, ve[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus.a         = 8'h0B;
      bus.b         = 8'h0D;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid  = 1'b0;
      wait_valid(lat);
      checks++;
      if (lat !== 4) begin
         errors++; $display("FAIL bp_latency: got %0d expected 4", lat);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.product !== 16'h008F || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_%0d: got product=%h in_ready=%b out_valid=%b expected 008f/0/1",
                     i, bus.product, bus.in_ready, bus.out_valid);
         end
         bus.a = ~bus.a;
         bus.b = bus.b + 8'h11;
         tick();
      end
      checks++;
      if (bus.product !== 16'h008F) begin
         errors++; $display("FAIL bp_after_toggle: got %h expected 008f", bus.product);
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready_passthrough: got %b expected 1", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_handoff: got out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2;
      bus.a         = 8'h10;
      bus.b         = 8'h10;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      // Next pair presented early; must only be taken at the handoff edge
      bus.a = 8'h03;
      bus.b = 8'h07;
      wait_valid(lat1);
      checks++;
      if (bus.product !== 16'h0100 || lat1 !== 4) begin
         errors++; $display("FAIL b2b_first: got %h (lat %0d) expected 0100 (lat 4)", bus.product, lat1);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_in_ready_done: got %b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      wait_valid(lat2);
      checks++;
      if (lat2 + 1 !== 5) begin
         errors++; $display("FAIL b2b_spacing: got %0d expected 5", lat2 + 1);
      end
      checks++;
      if (bus.product !== 16'h0015) begin
         errors++; $display("FAIL b2b_second: got %h expected 0015", bus.product);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [15:0] p;
      int          lat;
      int          pulses;
      bus.a         = 8'hFF;
      bus.b         = 8'hFF;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.product !== 16'h0000 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state: got in_ready=%b product=%h out_valid=%b expected 1/0000/0",
                  bus.in_ready, bus.product, bus.out_valid);
      end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.out_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", pulses);
      end
      run_op(8'h02, 8'h03, p, lat);
      checks++;
      if (p !== 16'h0006 || lat !== 4) begin
         errors++; $display("FAIL rst_mid_next_op: got %h (lat %0d) expected 0006 (lat 4)", p, lat);
      end
   endtask

   task automatic test_in_valid_during_mul();
      int lat;
      int pulses;
      bus.a         = 8'h21;
      bus.b         = 8'h05;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
      tick();
      bus.a         = 8'hFF;
      bus.b         = 8'hFF;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
      wait_valid(lat);
      checks++;
      if (bus.product !== 16'h00A5 || lat + 2 !== 4) begin
         errors++; $display("FAIL mul_ignore_result: got %h (lat %0d) expected 00a5 (lat 4)",
                            bus.product, lat + 2);
      end
      tick();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.out_valid) pulses++;
         tick();
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL mul_ignore_extra: got %0d extra results expected 0", pulses);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = 8'h00;
      bus.b         = 8'h00;
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_corners();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_in_valid_during_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
